// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Fetch/decode/dispatch controller for the instruction ROM. Reads one 32-bit
// word per instruction, splits it into opcode/dest/src1/src2, hands it to the
// execution unit over a valid/ready handshake, waits for completion and then
// advances the PC. A stop opcode halts the program without being issued.
// Illegal opcodes and running past the last ROM word also halt and raise the
// sticky illegal flag.
//
// Handshake: the instruction is offered while issueValid is high. The fields
// are held stable until the cycle in which issueReady is also high. That
// rising edge is the accept edge. issueReady is ignored in every other state.
// exeDone is honoured only in EXEC, so a pulse coincident with the accept edge
// is not taken as completion of the instruction.
//
// ROM_DEPTH must be in 1..16 because pc is 4 bits wide and never wraps.

`timescale 1ns/1ps

module instruction_sequencer #(
  parameter int          ROM_DEPTH   = 6,
  parameter logic [7:0]  STOP_OPCODE = 8'h05,
  parameter logic [7:0]  MAX_OPCODE  = 8'h05,
  parameter logic [3:0]  INSTR_ID    = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] addressBus,
  output logic        readFromInst,
  input  logic [31:0] instructionData,
  output logic        issueValid,
  input  logic        issueReady,
  output logic [7:0]  opcode,
  output logic [7:0]  dest,
  output logic [7:0]  src1,
  output logic [7:0]  src2,
  input  logic        exeDone,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  dbg_state_o
);

  // State encoding is visible on dbg_state_o. IDLE=0 FETCH=1 WAIT=2 DECODE=3
  // ISSUE=4 EXEC=5 HALT=6.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_ISSUE  = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0]  LAST_PC   = 4'(ROM_DEPTH - 1);
  localparam logic [15:0] IDLE_ADDR = 16'hF000;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic        start_ok;
  logic        is_stop;
  logic        is_bad_op;
  logic        at_last;

  // Small decode helpers shared by the next-state logic.
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign is_stop   = (ir_q[31:24] == STOP_OPCODE);
  assign is_bad_op = (ir_q[31:24] > MAX_OPCODE);
  assign at_last   = (pc_q == LAST_PC);

  // State register and datapath registers. Reset aborts at once, whatever the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 4'd0;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic for the FSM, the PC, the instruction register and the sticky error.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          pc_d      = 4'd0;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        // The ROM answers in the following cycle. The fetch strobe lasts one cycle.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        ir_d    = instructionData;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_stop) begin
          state_d = S_HALT;
        end else if (is_bad_op) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issueReady) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exeDone) begin
          if (at_last) begin
            // The program ran off the end without a stop word.
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            pc_d    = pc_q + 4'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state only. Reset therefore clears outputs asynchronously.
  always_comb begin
    addressBus   = IDLE_ADDR;
    readFromInst = 1'b0;
    issueValid   = 1'b0;
    busy         = 1'b1;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_FETCH: begin
        readFromInst = 1'b1;
        addressBus   = {INSTR_ID, pc_q, 8'h00};
      end
      S_ISSUE: begin
        issueValid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign opcode      = ir_q[31:24];
  assign dest        = ir_q[23:16];
  assign src1        = ir_q[15:8];
  assign src2        = ir_q[7:0];
  assign pc          = pc_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

  // The fetch strobe never lasts longer than one cycle.
  a_fetch_one_cycle: assert property (@(posedge clk) disable iff (reset)
    readFromInst |=> !readFromInst);

  // An offered instruction stays offered and unchanged until it is accepted.
  a_issue_hold: assert property (@(posedge clk) disable iff (reset)
    (issueValid && !issueReady) |=> (issueValid && $stable({opcode, dest, src1, src2})));

  // The PC stays inside the ROM.
  a_pc_range: assert property (@(posedge clk) disable iff (reset)
    pc_q <= LAST_PC);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer. The bench models a ROM that
// answers one cycle after the fetch strobe. It also models an execution unit
// that raises exeDone two cycles after each accept. A second instance with
// ROM_DEPTH=3 runs the same program to exercise the overrun halt.

`timescale 1ns/1ps

module tb_instruction_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_WAIT = 3'd2,
                         S_ISSUE = 3'd4, S_EXEC = 3'd5, S_HALT = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (ROM_DEPTH = 6) ----------------
  logic [15:0] addressBus;
  logic        readFromInst;
  logic [31:0] idata = 32'd0;
  logic        issueValid;
  logic        issueReady = 1'b1;
  logic [7:0]  opcode, dest, src1, src2;
  logic        exeDone;
  logic [3:0]  pc;
  logic        busy, halted, illegal;
  logic [2:0]  dbg_state;

  // ---------------- DUT 2 (ROM_DEPTH = 3) ----------------
  logic [15:0] addressBus2;
  logic        readFromInst2;
  logic [31:0] idata2 = 32'd0;
  logic        issueValid2;
  logic [7:0]  opcode2, dest2, src1_2, src2_2;
  logic        exeDone2;
  logic [3:0]  pc2;
  logic        busy2, halted2, illegal2;
  logic [2:0]  dbg_state2;

  logic [31:0] rom [16];

  logic done_auto = 1'b0, done_man = 1'b0, done_auto2 = 1'b0;
  assign exeDone  = done_auto | done_man;
  assign exeDone2 = done_auto2;

  instruction_sequencer #(.ROM_DEPTH(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .addressBus(addressBus), .readFromInst(readFromInst), .instructionData(idata),
    .issueValid(issueValid), .issueReady(issueReady),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .exeDone(exeDone), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal),
    .dbg_state_o(dbg_state)
  );

  instruction_sequencer #(.ROM_DEPTH(3)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .addressBus(addressBus2), .readFromInst(readFromInst2), .instructionData(idata2),
    .issueValid(issueValid2), .issueReady(1'b1),
    .opcode(opcode2), .dest(dest2), .src1(src1_2), .src2(src2_2),
    .exeDone(exeDone2), .pc(pc2), .busy(busy2), .halted(halted2), .illegal(illegal2),
    .dbg_state_o(dbg_state2)
  );

  // ROM models: the word is valid in the cycle after the fetch strobe.
  always @(posedge clk) begin
    if (readFromInst)  idata  <= rom[addressBus[11:8]];
    if (readFromInst2) idata2 <= rom[addressBus2[11:8]];
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- execution-unit model / monitor ----------------
  logic stall_en = 1'b0;
  logic rdy_block = 1'b0;
  int   stall_run = 0, stall_cycles = 0;
  int   fetches = 0, issues = 0, issues2 = 0;
  int   exe_cnt = 0, exe_cnt2 = 0;

  always @(negedge clk) begin
    if (readFromInst) fetches++;
    if (!stall_en) stall_run = 0;
    if (rdy_block) begin
      issueReady = 1'b0;
    end else if (issueValid && stall_en && pc == 4'd2 && stall_run < 7) begin
      issueReady = 1'b0;
      stall_run++;
      stall_cycles++;
      if (exp_q.size() > 0) check("stall_hold", {opcode, dest, src1, src2}, exp_q[0]);
      else check("stall_hold_unexpected", 32'd1, 32'd0);
    end else begin
      issueReady = 1'b1;
    end
    done_auto = (exe_cnt == 1);
    if (exe_cnt > 0) exe_cnt--;
    done_auto2 = (exe_cnt2 == 1);
    if (exe_cnt2 > 0) exe_cnt2--;
    if (reset) begin
      exe_cnt = 0; done_auto = 1'b0; exe_cnt2 = 0; done_auto2 = 1'b0;
    end
    if (issueValid && issueReady) begin
      issues++;
      exe_cnt = 2;
      if (exp_q.size() > 0) check("issue_word", {opcode, dest, src1, src2}, exp_q.pop_front());
      else check("unexpected_issue", {opcode, dest, src1, src2}, 32'hxxxx_xxxx);
    end
    if (issueValid2) begin
      issues2++;
      exe_cnt2 = 2;
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [31:0] word;
    logic [7:0]  op, dst, s1, s2;
    logic        issued;
  } vec_t;
  vec_t vecs[6];

  task automatic load_program();
    exp_q.delete();
    for (int i = 0; i < 16; i++) rom[i] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      rom[i] = vecs[i].word;
      if (vecs[i].issued) exp_q.push_back({vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < budget);
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] st, input logic [3:0] at_pc, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dbg_state == st && pc == at_pc) && n < budget);
    check("state_reached", {25'd0, pc, dbg_state}, {25'd0, at_pc, st});
  endtask

  int f0, i0, i2_0, s0;

  initial begin
    vecs[0] = '{32'h00020001, 8'h00, 8'h02, 8'h00, 8'h01, 1'b1};
    vecs[1] = '{32'h01030002, 8'h01, 8'h03, 8'h00, 8'h02, 1'b1};
    vecs[2] = '{32'h02040200, 8'h02, 8'h04, 8'h02, 8'h00, 1'b1};
    vecs[3] = '{32'h03050506, 8'h03, 8'h05, 8'h05, 8'h06, 1'b1};
    vecs[4] = '{32'h04060305, 8'h04, 8'h06, 8'h03, 8'h05, 1'b1};
    vecs[5] = '{32'h05000000, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0};
    load_program();

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", {16'd0, addressBus}, 32'h0000F000);
    check("rst_addr2", {16'd0, addressBus2}, 32'h0000F000);
    check("rst_ctrl", {27'd0, readFromInst, issueValid, busy, halted, illegal}, 32'd0);
    check("rst_fields", {opcode, dest, src1, src2}, 32'd0);
    check("rst_pc_state", {25'd0, pc, dbg_state}, {25'd0, 4'd0, S_IDLE});
    @(posedge clk); #1 reset = 1'b0;

    // ---- T1 default program + T4 overrun on the depth-3 instance ----
    f0 = fetches; i0 = issues; i2_0 = issues2;
    pulse_start();
    check("t1_first_fetch", {15'd0, readFromInst, addressBus}, 32'h00010000);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_halt(300);
    check("t1_pc", {28'd0, pc}, 32'd5);
    check("t1_illegal", {31'd0, illegal}, 32'd0);
    check("t1_fetches", fetches - f0, 32'd6);
    check("t1_issues", issues - i0, 32'd5);
    check("t1_queue_empty", exp_q.size(), 32'd0);
    check("t1_halt_addr", {16'd0, addressBus}, 32'h0000F000);
    check("t4_halted", {31'd0, halted2}, 32'd1);
    check("t4_pc", {28'd0, pc2}, 32'd2);
    check("t4_illegal", {31'd0, illegal2}, 32'd1);
    check("t4_issues", issues2 - i2_0, 32'd3);

    // ---- T2 backpressure on instruction 2 ----
    load_program();
    stall_en = 1'b1;
    f0 = fetches; i0 = issues; s0 = stall_cycles;
    pulse_start();
    wait_halt(300);
    stall_en = 1'b0;
    check("t2_stall_cycles", stall_cycles - s0, 32'd7);
    check("t2_issues", issues - i0, 32'd5);
    check("t2_fetches", fetches - f0, 32'd6);
    check("t2_queue_empty", exp_q.size(), 32'd0);
    check("t2_pc", {28'd0, pc}, 32'd5);

    // ---- T3 illegal opcode at pc 1 ----
    load_program();
    rom[1] = 32'h09000000;
    exp_q.delete();
    exp_q.push_back(32'h00020001);
    f0 = fetches; i0 = issues;
    pulse_start();
    wait_halt(300);
    check("t3_pc", {28'd0, pc}, 32'd1);
    check("t3_illegal", {31'd0, illegal}, 32'd1);
    check("t3_issues", issues - i0, 32'd1);
    check("t3_fetches", fetches - f0, 32'd2);
    exp_q.push_back(32'h00020001);
    pulse_start();
    check("t3_restart_clear", {31'd0, illegal}, 32'd0);
    check("t3_refetch", {15'd0, readFromInst, addressBus}, 32'h00010000);
    wait_halt(300);
    check("t3_again", {27'd0, illegal, pc}, {27'd0, 1'b1, 4'd1});

    // ---- T5 asynchronous reset while in EXEC at pc 3 ----
    load_program();
    i0 = issues;
    pulse_start();
    wait_state(S_EXEC, 4'd3, 300);
    #2 reset = 1'b1;
    #1;
    check("t5_addr", {16'd0, addressBus}, 32'h0000F000);
    check("t5_ctrl", {27'd0, readFromInst, issueValid, busy, halted, illegal}, 32'd0);
    check("t5_pc_state", {25'd0, pc, dbg_state}, {25'd0, 4'd0, S_IDLE});
    check("t5_fields", {opcode, dest, src1, src2}, 32'd0);
    check("t5_issues", issues - i0, 32'd4);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("t5_stays_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    load_program();
    pulse_start();
    wait_halt(300);
    check("t5_restart", {27'd0, illegal, pc}, {27'd0, 1'b0, 4'd5});
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // ---- T6 spurious exeDone and start while busy ----
    load_program();
    i0 = issues;
    rdy_block = 1'b1;
    pulse_start();
    done_man = 1'b1; start = 1'b1;
    @(posedge clk); #1 done_man = 1'b0; start = 1'b0;
    check("t6_fetch_ignore", {25'd0, pc, dbg_state}, {25'd0, 4'd0, S_WAIT});
    wait_state(S_ISSUE, 4'd0, 20);
    @(posedge clk); #1 done_man = 1'b1; start = 1'b1;
    @(posedge clk); #1 done_man = 1'b0; start = 1'b0;
    check("t6_issue_ignore", {25'd0, pc, dbg_state}, {25'd0, 4'd0, S_ISSUE});
    check("t6_issue_valid", {30'd0, issueValid, busy}, 32'd3);
    rdy_block = 1'b0; done_man = 1'b1;
    @(posedge clk); #1 done_man = 1'b0;
    check("t6_accept", {29'd0, dbg_state}, {29'd0, S_EXEC});
    @(posedge clk); #1;
    check("t6_done_at_accept_ignored", {25'd0, pc, dbg_state}, {25'd0, 4'd0, S_EXEC});
    wait_halt(300);
    check("t6_final", {27'd0, illegal, pc}, {27'd0, 1'b0, 4'd5});
    check("t6_issues", issues - i0, 32'd5);
    check("t6_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
